// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the UART ROM loader: frame/receiver states,
// sync byte, load window and the checksum accumulate helper.
package rom_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_CSUM   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam logic [7:0]  SYNC_BYTE  = 8'h43;
   localparam logic [11:0] START_ADDR = 12'h200;
   localparam logic [15:0] MAX_LEN    = 16'd3584;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Memory-side upload bus of the ROM loader: write strobe, address, data and
// frame status flags.
interface rom_loader_if;
   logic        uploading;
   logic        upload_en;
   logic [7:0]  upload_data;
   logic [11:0] upload_addr;
   logic        done;
   logic        error;

   modport master (
      output uploading, upload_en, upload_data, upload_addr, done, error
   );

   modport slave (
      input uploading, upload_en, upload_data, upload_addr, done, error
   );
endinterface

// File: rtl/rom_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB-first shifter.
// Emits one-cycle valid for a good byte or frame_err when the stop bit is low.
module uart_rx
   import rom_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 218
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o
);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   rx_state_t   state_q;
   logic [2:0]  sync_q;
   logic [15:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        ferr_q;

   // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RX_IDLE;
         sync_q  <= 3'b111;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], rxd_i};
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               cnt_q <= 16'd0;
               bit_q <= 3'd0;
               if (sync_q[2] && !sync_q[1]) begin
                  state_q <= RX_START;
               end else begin
                  state_q <= RX_IDLE;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q   <= 16'd0;
                  state_q <= sync_q[1] ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            RX_DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= 16'd0;
                  shift_q <= {sync_q[1], shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= RX_STOP;
                  end else begin
                     state_q <= RX_DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            RX_STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= 16'd0;
                  state_q <= RX_IDLE;
                  if (sync_q[1]) begin
                     valid_q <= 1'b1;
                     data_q  <= shift_q;
                  end else begin
                     ferr_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
endmodule

// File: rtl/rom_loader.sv
// UART ROM loader: frame FSM (sync, big-endian length, data, optional checksum),
// address/timeout counters. Define ROM_LOADER_CHECKSUM_EN for the trailing checksum byte.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 25152000,
   parameter int unsigned BAUD        = 115200,
   parameter int unsigned TIMEOUT_CYC = 2500000
) (
   input  logic           clk,
   input  logic           res,
   input  logic           rxd,
   rom_loader_if.master   up
);
   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

   logic [7:0]  rx_data_s;
   logic        rx_valid_s;
   logic        rx_ferr_s;
   logic [15:0] len_s;
   logic        timeout_s;

   state_t      state_q;
   logic [7:0]  len_hi_q;
   logic [11:0] rem_q;
   logic [11:0] addr_q;
   logic [31:0] tmo_q;
   logic        uploading_q;
   logic        upload_en_q;
   logic [7:0]  upload_data_q;
   logic [11:0] upload_addr_q;
   logic        done_q;
   logic        error_q;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q;
`endif

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
      .clk         (clk),
      .rst         (res),
      .rxd_i       (rxd),
      .data_o      (rx_data_s),
      .valid_o     (rx_valid_s),
      .frame_err_o (rx_ferr_s)
   );

   assign len_s     = {len_hi_q, rx_data_s};
   assign timeout_s = (state_q != S_IDLE) && (state_q != S_FINISH) && !rx_valid_s &&
                      !rx_ferr_s && (tmo_q >= 32'(TIMEOUT_CYC));

   // Frame FSM with registered bus outputs; the timeout abort takes priority over any state
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q       <= S_IDLE;
         len_hi_q      <= 8'h00;
         rem_q         <= 12'd0;
         addr_q        <= START_ADDR;
         tmo_q         <= 32'd0;
         uploading_q   <= 1'b0;
         upload_en_q   <= 1'b0;
         upload_data_q <= 8'h00;
         upload_addr_q <= START_ADDR;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
         csum_q        <= 8'h00;
`endif
      end else begin
         upload_en_q <= 1'b0;
         done_q      <= 1'b0;
         if ((state_q == S_IDLE) || rx_valid_s || rx_ferr_s) begin
            tmo_q <= 32'd0;
         end else begin
            tmo_q <= tmo_q + 32'd1;
         end
         if (rx_ferr_s && (state_q != S_IDLE)) begin
            error_q <= 1'b1;
         end else begin
            error_q <= error_q;
         end
         if (timeout_s) begin
            error_q     <= 1'b1;
            uploading_q <= 1'b0;
            state_q     <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  // uploading falls here one cycle after done
                  uploading_q <= rx_valid_s && (rx_data_s == SYNC_BYTE);
                  if (rx_valid_s && (rx_data_s == SYNC_BYTE)) begin
                     state_q <= S_LEN_HI;
                     error_q <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                     csum_q  <= 8'h00;
`endif
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               S_LEN_HI: begin
                  if (rx_valid_s) begin
                     len_hi_q <= rx_data_s;
                     state_q  <= S_LEN_LO;
                  end else begin
                     state_q  <= S_LEN_HI;
                  end
               end
               S_LEN_LO: begin
                  if (rx_valid_s && ((len_s == 16'd0) || (len_s > MAX_LEN))) begin
                     error_q     <= 1'b1;
                     uploading_q <= 1'b0;
                     state_q     <= S_IDLE;
                  end else if (rx_valid_s) begin
                     rem_q   <= len_s[11:0];
                     addr_q  <= START_ADDR;
                     state_q <= S_DATA;
                  end else begin
                     state_q <= S_LEN_LO;
                  end
               end
               S_DATA: begin
                  if (rx_valid_s) begin
                     upload_en_q   <= 1'b1;
                     upload_data_q <= rx_data_s;
                     upload_addr_q <= addr_q;
`ifdef ROM_LOADER_CHECKSUM_EN
                     csum_q        <= csum_add(csum_q, rx_data_s);
`endif
                     if (rem_q == 12'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_q <= S_CSUM;
`else
                        state_q <= S_FINISH;
`endif
                     end else begin
                        rem_q  <= rem_q - 12'd1;
                        addr_q <= addr_q + 12'd1;
                     end
                  end else begin
                     state_q <= S_DATA;
                  end
               end
`ifdef ROM_LOADER_CHECKSUM_EN
               S_CSUM: begin
                  if (rx_valid_s && (rx_data_s == csum_q)) begin
                     state_q <= S_FINISH;
                  end else if (rx_valid_s) begin
                     error_q     <= 1'b1;
                     uploading_q <= 1'b0;
                     state_q     <= S_IDLE;
                  end else begin
                     state_q <= S_CSUM;
                  end
               end
`endif
               S_FINISH: begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
               default: begin
                  uploading_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign up.uploading   = uploading_q;
   assign up.upload_en   = upload_en_q;
   assign up.upload_data = upload_data_q;
   assign up.upload_addr = upload_addr_q;
   assign up.done        = done_q;
   assign up.error       = error_q;
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: serial frames on rxd, strobes collected by a monitor.
// Honors ROM_LOADER_CHECKSUM_EN to append checksum bytes and run the mismatch scenario.
module tb_rom_loader;
   localparam int unsigned CLK_HZ = 1000000;
   localparam int unsigned BAUD   = 100000;
   localparam int unsigned CPB    = 10;
   localparam int unsigned TMO    = 300;

   logic clk = 1'b0;
   logic res = 1'b1;
   logic rxd = 1'b1;

   rom_loader_if up_if ();

   rom_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TMO)) dut (
      .clk (clk),
      .res (res),
      .rxd (rxd),
      .up  (up_if)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;
   logic [11:0] q_addr[$];
   logic [7:0]  q_data[$];
   int done_cnt = 0;
   int upl_cyc  = 0;
   int viol     = 0;

   always @(negedge clk) begin
      if (up_if.upload_en) begin
         q_addr.push_back(up_if.upload_addr);
         q_data.push_back(up_if.upload_data);
      end
      if (up_if.done) done_cnt++;
      if (up_if.uploading) upl_cyc++;
      if (up_if.upload_en && !up_if.uploading) viol++;
   end

   task automatic clear_mon();
      q_addr.delete();
      q_data.delete();
      done_cnt = 0;
      upl_cyc  = 0;
   endtask

   task automatic send_raw(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_raw(b, 1'b1);
   endtask

   task automatic test_reset();
      res = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (up_if.uploading !== 1'b0) $display("FAIL rst_uploading actual=%0b required=0", up_if.uploading); else passed++;
      total++; if (up_if.upload_en !== 1'b0) $display("FAIL rst_upload_en actual=%0b required=0", up_if.upload_en); else passed++;
      total++; if (up_if.done !== 1'b0) $display("FAIL rst_done actual=%0b required=0", up_if.done); else passed++;
      total++; if (up_if.error !== 1'b0) $display("FAIL rst_error actual=%0b required=0", up_if.error); else passed++;
      total++; if (up_if.upload_data !== 8'h00) $display("FAIL rst_data actual=%h required=00", up_if.upload_data); else passed++;
      total++; if (up_if.upload_addr !== 12'h200) $display("FAIL rst_addr actual=%h required=200", up_if.upload_addr); else passed++;
      res = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_ignore_pre_sync();
      clear_mon();
      send_byte(8'h55);
      send_byte(8'h00);
      total++; if (q_addr.size() !== 0) $display("FAIL ignore_strobes actual=%0d required=0", q_addr.size()); else passed++;
      total++; if (upl_cyc !== 0) $display("FAIL ignore_uploading cycles_high=%0d required=0", upl_cyc); else passed++;
   endtask

   task automatic test_frame();
      logic [11:0] ea[3];
      logic [7:0]  ed[3];
      ea = '{12'h200, 12'h201, 12'h202};
      ed = '{8'hA2, 8'hB4, 8'hC6};
      clear_mon();
      send_byte(8'h43);
      total++; if (up_if.uploading !== 1'b1) $display("FAIL frame_uploading_mid actual=%0b required=1", up_if.uploading); else passed++;
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'hA2);
      send_byte(8'hB4);
      send_byte(8'hC6);
`ifdef ROM_LOADER_CHECKSUM_EN
      send_byte(8'h1C);
`endif
      repeat (4) @(negedge clk);
      total++; if (q_addr.size() !== 3) $display("FAIL frame_strobes actual=%0d required=3", q_addr.size()); else passed++;
      for (int i = 0; i < 3; i++) begin
         if (i < q_addr.size()) begin
            total++; if (q_addr[i] !== ea[i] || q_data[i] !== ed[i]) $display("FAIL frame_byte%0d actual=%h/%h required=%h/%h", i, q_addr[i], q_data[i], ea[i], ed[i]); else passed++;
         end
      end
      total++; if (done_cnt !== 1) $display("FAIL frame_done actual=%0d required=1", done_cnt); else passed++;
      total++; if (up_if.error !== 1'b0) $display("FAIL frame_error actual=%0b required=0", up_if.error); else passed++;
      total++; if (up_if.uploading !== 1'b0) $display("FAIL frame_uploading_end actual=%0b required=0", up_if.uploading); else passed++;
   endtask

   task automatic test_bad_len();
      clear_mon();
      send_byte(8'h43);
      send_byte(8'h0E);
      send_byte(8'h01);
      total++; if (up_if.error !== 1'b1) $display("FAIL len_big_error actual=%0b required=1", up_if.error); else passed++;
      total++; if (up_if.uploading !== 1'b0) $display("FAIL len_big_uploading actual=%0b required=0", up_if.uploading); else passed++;
      send_byte(8'hAA);
      total++; if (q_addr.size() !== 0) $display("FAIL len_big_strobes actual=%0d required=0", q_addr.size()); else passed++;
      send_byte(8'h43);
      total++; if (up_if.error !== 1'b0) $display("FAIL sync_clears_error actual=%0b required=0", up_if.error); else passed++;
      send_byte(8'h00);
      send_byte(8'h00);
      total++; if (up_if.error !== 1'b1) $display("FAIL len_zero_error actual=%0b required=1", up_if.error); else passed++;
      total++; if (q_addr.size() !== 0) $display("FAIL len_zero_strobes actual=%0d required=0", q_addr.size()); else passed++;
   endtask

   task automatic test_sync_in_data();
      clear_mon();
      send_byte(8'h43);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h43);
      send_byte(8'h43);
`ifdef ROM_LOADER_CHECKSUM_EN
      send_byte(8'h86);
`endif
      total++; if (q_addr.size() !== 2) $display("FAIL sync_data_strobes actual=%0d required=2", q_addr.size()); else passed++;
      if (q_addr.size() == 2) begin
         total++; if (q_addr[1] !== 12'h201 || q_data[1] !== 8'h43) $display("FAIL sync_data_byte1 actual=%h/%h required=201/43", q_addr[1], q_data[1]); else passed++;
      end
      total++; if (done_cnt !== 1) $display("FAIL sync_data_done actual=%0d required=1", done_cnt); else passed++;
   endtask

   task automatic test_timeout();
      clear_mon();
      send_byte(8'h43);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      total++; if (up_if.uploading !== 1'b1) $display("FAIL tmo_uploading_before actual=%0b required=1", up_if.uploading); else passed++;
      repeat (TMO + 100) @(negedge clk);
      total++; if (q_addr.size() !== 2) $display("FAIL tmo_strobes actual=%0d required=2", q_addr.size()); else passed++;
      total++; if (up_if.error !== 1'b1) $display("FAIL tmo_error actual=%0b required=1", up_if.error); else passed++;
      total++; if (up_if.uploading !== 1'b0) $display("FAIL tmo_uploading actual=%0b required=0", up_if.uploading); else passed++;
      total++; if (done_cnt !== 0) $display("FAIL tmo_done actual=%0d required=0", done_cnt); else passed++;
      clear_mon();
      send_byte(8'h43);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h5A);
`ifdef ROM_LOADER_CHECKSUM_EN
      send_byte(8'h5A);
`endif
      total++; if (up_if.error !== 1'b0) $display("FAIL tmo_recover_error actual=%0b required=0", up_if.error); else passed++;
      total++; if (done_cnt !== 1) $display("FAIL tmo_recover_done actual=%0d required=1", done_cnt); else passed++;
      if (q_addr.size() == 1) begin
         total++; if (q_addr[0] !== 12'h200 || q_data[0] !== 8'h5A) $display("FAIL tmo_recover_byte actual=%h/%h required=200/5a", q_addr[0], q_data[0]); else passed++;
      end else begin
         total++; $display("FAIL tmo_recover_strobes actual=%0d required=1", q_addr.size());
      end
   endtask

   task automatic test_framing();
      clear_mon();
      send_raw(8'h43, 1'b0);
      total++; if (up_if.uploading !== 1'b0) $display("FAIL ferr_idle_uploading actual=%0b required=0", up_if.uploading); else passed++;
      total++; if (up_if.error !== 1'b0) $display("FAIL ferr_idle_error actual=%0b required=0", up_if.error); else passed++;
      send_byte(8'h43);
      send_raw(8'h00, 1'b0);
      total++; if (up_if.error !== 1'b1) $display("FAIL ferr_frame_error actual=%0b required=1", up_if.error); else passed++;
      total++; if (up_if.uploading !== 1'b1) $display("FAIL ferr_frame_uploading actual=%0b required=1", up_if.uploading); else passed++;
      repeat (TMO + 100) @(negedge clk);
      total++; if (up_if.uploading !== 1'b0) $display("FAIL ferr_abort_uploading actual=%0b required=0", up_if.uploading); else passed++;
   endtask

`ifdef ROM_LOADER_CHECKSUM_EN
   task automatic test_csum_bad();
      clear_mon();
      send_byte(8'h43);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h11);
      total++; if (q_addr.size() !== 1) $display("FAIL csum_strobes actual=%0d required=1", q_addr.size()); else passed++;
      total++; if (up_if.error !== 1'b1) $display("FAIL csum_error actual=%0b required=1", up_if.error); else passed++;
      total++; if (done_cnt !== 0) $display("FAIL csum_done actual=%0d required=0", done_cnt); else passed++;
      total++; if (up_if.uploading !== 1'b0) $display("FAIL csum_uploading actual=%0b required=0", up_if.uploading); else passed++;
   endtask
`endif

   task automatic test_reset_mid();
      clear_mon();
      send_byte(8'h43);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h01);
      total++; if (q_addr.size() !== 1) $display("FAIL rmid_first_strobe actual=%0d required=1", q_addr.size()); else passed++;
      rxd = 1'b0;
      repeat (25) @(negedge clk);
      res = 1'b1;
      #1;
      total++; if (up_if.uploading !== 1'b0) $display("FAIL rmid_uploading actual=%0b required=0", up_if.uploading); else passed++;
      total++; if (up_if.upload_data !== 8'h00) $display("FAIL rmid_data actual=%h required=00", up_if.upload_data); else passed++;
      total++; if (up_if.upload_addr !== 12'h200) $display("FAIL rmid_addr actual=%h required=200", up_if.upload_addr); else passed++;
      total++; if (up_if.error !== 1'b0 || up_if.done !== 1'b0 || up_if.upload_en !== 1'b0) $display("FAIL rmid_flags actual=%0b%0b%0b required=000", up_if.error, up_if.done, up_if.upload_en); else passed++;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      res = 1'b0;
      repeat (20) @(negedge clk);
      send_byte(8'h02);
      send_byte(8'h03);
      total++; if (q_addr.size() !== 1) $display("FAIL rmid_no_more_strobes actual=%0d required=1", q_addr.size()); else passed++;
      total++; if (up_if.uploading !== 1'b0) $display("FAIL rmid_after_uploading actual=%0b required=0", up_if.uploading); else passed++;
   endtask

   initial begin
      test_reset();
      test_ignore_pre_sync();
      test_frame();
      test_bad_len();
      test_sync_in_data();
      test_timeout();
      test_framing();
`ifdef ROM_LOADER_CHECKSUM_EN
      test_csum_bad();
`endif
      test_reset_mid();
      total++; if (viol !== 0) $display("FAIL strobe_without_uploading count=%0d required=0", viol); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
